// File: rtl/smart_scrub.sv
// Safe-area scrubber: on violation or request, holds the CPU, fills [LOW_SAFE, HIGH_SAFE]
// with FILL, reads every word back, and flags any mismatch in a sticky scrub_err.
module smart_scrub #(
  parameter int          SIZE_MEM_ADDR = 15,
  parameter int unsigned LOW_SAFE      = 200,
  parameter int unsigned HIGH_SAFE     = 200,
  parameter logic [15:0] FILL          = 16'h0000
) (
  input  logic                   mclk,
  input  logic                   reset_n,
  input  logic                   violation,
  input  logic                   scrub_req,
  input  logic [15:0]            mem_dout,
  output logic                   cpu_hold,
  output logic                   busy,
  output logic [SIZE_MEM_ADDR:0] mem_addr,
  output logic [15:0]            mem_din,
  output logic                   mem_cen,
  output logic [1:0]             mem_wen,
  output logic                   done,
  output logic                   scrub_err
);

  localparam int AW = SIZE_MEM_ADDR + 1;
  localparam logic [AW-1:0] LOW_A  = AW'(LOW_SAFE);
  localparam logic [AW-1:0] HIGH_A = AW'(HIGH_SAFE);

  typedef enum logic [2:0] {IDLE, WR, RD, CMP, DONE} state_t;

  typedef struct packed {
    logic          cen;
    logic [1:0]    wen;
    logic [AW-1:0] addr;
    logic [15:0]   din;
  } mem_req_t;

  state_t        state, state_nxt;
  logic [AW-1:0] addr, addr_nxt;
  logic          pending, pending_nxt;
  logic          err_nxt;
  logic          trig;
  logic          at_high;
  mem_req_t      req;

  assign trig    = violation | scrub_req;
  assign at_high = (addr == HIGH_A);

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      addr      <= '0;
      pending   <= 1'b0;
      scrub_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      addr      <= addr_nxt;
      pending   <= pending_nxt;
      scrub_err <= err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    addr_nxt    = addr;
    pending_nxt = pending;
    err_nxt     = scrub_err;
    // Triggers arriving while busy are folded into one queued restart.
    if (state != IDLE && trig) pending_nxt = 1'b1;
    case (state)
      IDLE: begin
        if (trig | pending) begin
          state_nxt   = WR;
          addr_nxt    = LOW_A;
          pending_nxt = 1'b0;
          err_nxt     = 1'b0;
        end
      end
      WR: begin
        if (at_high) begin
          state_nxt = RD;
          addr_nxt  = LOW_A;
        end else begin
          addr_nxt  = addr + 1'b1;
        end
      end
      RD: state_nxt = CMP;
      CMP: begin
        // mem_dout here is the data for the read strobed in the preceding RD cycle.
        if (mem_dout != FILL) err_nxt = 1'b1;
        if (at_high) begin
          state_nxt = DONE;
        end else begin
          state_nxt = RD;
          addr_nxt  = addr + 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req.cen  = 1'b1;
    req.wen  = 2'b11;
    req.addr = '0;
    req.din  = '0;
    case (state)
      WR: begin
        req.cen  = 1'b0;
        req.wen  = 2'b00;
        req.addr = addr;
        req.din  = FILL;
      end
      RD: begin
        req.cen  = 1'b0;
        req.addr = addr;
        req.din  = FILL;
      end
      CMP, DONE: begin
        req.addr = addr;
        req.din  = FILL;
      end
      default: ;
    endcase
  end

  assign mem_cen  = req.cen;
  assign mem_wen  = req.wen;
  assign mem_addr = req.addr;
  assign mem_din  = req.din;
  assign busy     = (state != IDLE);
  assign cpu_hold = busy;
  assign done     = (state == DONE);

endmodule

// File: tb/tb_smart_scrub.sv
// Bench for smart_scrub: two instances (4-word and 1-word safe areas) against a
// phase-index reference model, with a synchronous memory model that can inject a read fault.
module tb_smart_scrub;

  localparam int          LOW  = 200;
  localparam logic [15:0] FILL = 16'hA5A5;
  localparam int          NW [2] = '{4, 1};

  logic        mclk;
  logic        reset_n;
  logic        violation, scrub_req;
  logic [15:0] dout     [2];
  logic        cpu_hold [2];
  logic        busy     [2];
  logic [15:0] addr     [2];
  logic [15:0] din      [2];
  logic        cen      [2];
  logic [1:0]  wen      [2];
  logic        done     [2];
  logic        err      [2];

  logic [15:0] mem [2][256];
  bit          fault_en   [2];
  logic [15:0] fault_addr [2];

  int idx  [2];
  bit pend [2];
  bit merr [2];

  int tests, fails;
  int busy_cnt [2];
  int done_cnt [2];
  int wr_cnt   [2];

  smart_scrub #(.SIZE_MEM_ADDR(15), .LOW_SAFE(200), .HIGH_SAFE(203), .FILL(16'hA5A5)) u_four (
    .mclk(mclk), .reset_n(reset_n), .violation(violation), .scrub_req(scrub_req),
    .mem_dout(dout[0]), .cpu_hold(cpu_hold[0]), .busy(busy[0]), .mem_addr(addr[0]),
    .mem_din(din[0]), .mem_cen(cen[0]), .mem_wen(wen[0]), .done(done[0]), .scrub_err(err[0])
  );

  smart_scrub #(.SIZE_MEM_ADDR(15), .LOW_SAFE(200), .HIGH_SAFE(200), .FILL(16'hA5A5)) u_one (
    .mclk(mclk), .reset_n(reset_n), .violation(violation), .scrub_req(scrub_req),
    .mem_dout(dout[1]), .cpu_hold(cpu_hold[1]), .busy(busy[1]), .mem_addr(addr[1]),
    .mem_din(din[1]), .mem_cen(cen[1]), .mem_wen(wen[1]), .done(done[1]), .scrub_err(err[1])
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  // Synchronous memory, one-cycle read latency; scrambled to non-FILL contents in reset.
  always @(posedge mclk) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset_n) begin
        for (int i = 0; i < 256; i++) mem[k][i] <= FILL ^ 16'($urandom_range(1, 65535));
      end else if (!cen[k]) begin
        if (wen[k] == 2'b00) mem[k][addr[k][7:0]] <= din[k];
        else if (wen[k] == 2'b11)
          dout[k] <= (fault_en[k] && addr[k] == fault_addr[k]) ? 16'h0000 : mem[k][addr[k][7:0]];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      idx[k] = -1; pend[k] = 1'b0; merr[k] = 1'b0;
    end
  endtask

  // Scrub of N words is one busy window of 3N+1 cycles: N writes, N read/compare pairs, done.
  task automatic model_step(input bit trig);
    int n, a;
    for (int k = 0; k < 2; k++) begin
      n = NW[k];
      if (!reset_n) begin
        idx[k] = -1; pend[k] = 1'b0; merr[k] = 1'b0;
      end else if (idx[k] < 0) begin
        if (trig || pend[k]) begin
          idx[k] = 0; pend[k] = 1'b0; merr[k] = 1'b0;
        end
      end else begin
        if (trig) pend[k] = 1'b1;
        if (idx[k] >= n && idx[k] < 3*n && ((idx[k] - n) % 2 == 1)) begin
          a = LOW + (idx[k] - n) / 2;
          if (fault_en[k] && int'(fault_addr[k]) == a) merr[k] = 1'b1;
        end
        idx[k]++;
        if (idx[k] > 3*n) idx[k] = -1;
      end
    end
  endtask

  task automatic check_all();
    int n, i, j;
    logic eb, ed, ec;
    logic [1:0] ew;
    logic [15:0] ea;
    for (int k = 0; k < 2; k++) begin
      n = NW[k]; i = idx[k];
      eb = 1'b1; ed = 1'b0; ec = 1'b1; ew = 2'b11; ea = 16'(LOW + n - 1);
      if (i < 0) begin
        eb = 1'b0; ea = 16'h0;
      end else if (i < n) begin
        ec = 1'b0; ew = 2'b00; ea = 16'(LOW + i);
      end else if (i < 3*n) begin
        j = i - n; ea = 16'(LOW + j / 2); ec = (j % 2 == 1);
      end else begin
        ed = 1'b1;
      end
      chk($sformatf("busy%0d", k), busy[k], eb);
      chk($sformatf("hold%0d", k), cpu_hold[k], eb);
      chk($sformatf("done%0d", k), done[k], ed);
      chk($sformatf("cen%0d", k), cen[k], ec);
      chk($sformatf("din%0d", k), din[k], eb ? FILL : 16'h0);
      chk($sformatf("err%0d", k), err[k], merr[k]);
      if (i < 0 || !ec) begin
        chk($sformatf("wen%0d", k), wen[k], ew);
        chk($sformatf("addr%0d", k), addr[k], ea);
      end
    end
  endtask

  task automatic cyc(input bit v, input bit s);
    violation = v; scrub_req = s;
    @(posedge mclk); #1;
    model_step(v | s);
    check_all();
    for (int k = 0; k < 2; k++) begin
      busy_cnt[k] += busy[k] ? 1 : 0;
      done_cnt[k] += done[k] ? 1 : 0;
      wr_cnt[k]   += (!cen[k] && wen[k] == 2'b00) ? 1 : 0;
    end
  endtask

  task automatic clr_cnt();
    for (int k = 0; k < 2; k++) begin
      busy_cnt[k] = 0; done_cnt[k] = 0; wr_cnt[k] = 0;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((idx[0] >= 0 || pend[0] || idx[1] >= 0 || pend[1]) && t < 200) begin
      cyc(1'b0, 1'b0); t++;
    end
    chk("drain_timeout", t < 200, 1'b1);
  endtask

  initial begin
    tests = 0; fails = 0;
    reset_n = 1'b0; violation = 1'b0; scrub_req = 1'b0;
    for (int k = 0; k < 2; k++) begin
      fault_en[k] = 1'b0; fault_addr[k] = 16'(LOW);
    end
    model_reset();
    clr_cnt();
    repeat (3) @(posedge mclk);
    #1;
    check_all();
    reset_n = 1'b1;

    // Basic scrub
    cyc(1'b0, 1'b0);
    clr_cnt();
    cyc(1'b1, 1'b0);
    repeat (20) cyc(1'b0, 1'b0);
    chk("dur4", busy_cnt[0], 13);
    chk("dur1", busy_cnt[1], 4);
    chk("done4", done_cnt[0], 1);
    chk("done1", done_cnt[1], 1);
    chk("wr4", wr_cnt[0], 4);
    chk("wr1", wr_cnt[1], 1);

    // Verify fault at 202, then a clean scrub clears the flag
    fault_en[0] = 1'b1; fault_addr[0] = 16'd202;
    fault_en[1] = 1'b1; fault_addr[1] = 16'd200;
    cyc(1'b0, 1'b1);
    repeat (20) cyc(1'b0, 1'b0);
    chk("err_sticky4", err[0], 1'b1);
    chk("err_sticky1", err[1], 1'b1);
    fault_en[0] = 1'b0; fault_en[1] = 1'b0;
    cyc(1'b1, 1'b0);
    chk("err_clr4", err[0], 1'b0);
    drain();

    // Trigger during WR of 201 queues exactly one more scrub
    clr_cnt();
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    repeat (35) cyc(1'b0, 1'b0);
    chk("twice_done4", done_cnt[0], 2);
    chk("twice_busy4", busy_cnt[0], 26);
    chk("twice_done1", done_cnt[1], 2);
    chk("twice_busy1", busy_cnt[1], 8);

    // Reset during RD of 201
    cyc(1'b1, 1'b0);
    begin
      int t;
      t = 0;
      while (idx[0] != NW[0] + 2 && t < 20) begin
        cyc(1'b0, 1'b0); t++;
      end
      chk("rd201_timeout", t < 20, 1'b1);
    end
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("rst_cen", cen[0], 1'b1);
    chk("rst_busy", busy[0], 1'b0);
    chk("rst_err", err[0], 1'b0);
    check_all();
    repeat (2) cyc(1'b0, 1'b0);
    reset_n = 1'b1;
    clr_cnt();
    repeat (20) cyc(1'b0, 1'b0);
    chk("post_rst_acc4", busy_cnt[0], 0);

    // Idle quiet
    repeat (100) cyc(1'b0, 1'b0);

    // Randomized traffic with random fault placement
    for (int blk = 0; blk < 8; blk++) begin
      drain();
      fault_en[0]   = $urandom_range(0, 1) == 1;
      fault_addr[0] = 16'(LOW + $urandom_range(0, 3));
      fault_en[1]   = $urandom_range(0, 1) == 1;
      fault_addr[1] = 16'(LOW);
      repeat (300) cyc($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 3);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
